ultrasonic_ranger_mc: RTL and testbench

//  Multi-channel HC-SR04-class ultrasonic ranger controller.

---
 rtl/ultrasonic_ranger_mc_pkg.sv | 23 ++
 rtl/ultrasonic_ranger_mc_if.sv | 28 ++
 rtl/ultrasonic_ranger_mc_echo_sync.sv | 18 +
 rtl/ultrasonic_ranger_mc.sv | 155 +++++++++++++++
 tb/tb_ultrasonic_ranger_mc.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ultrasonic_ranger_mc_pkg.sv
// Shared FSM encodings and elaboration-time timing helpers for the multi-channel ranger.
package ultrasonic_ranger_mc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_TRIG      = 3'd1;
  localparam state_t S_WAIT_RISE = 3'd2;
  localparam state_t S_MEASURE   = 3'd3;
  localparam state_t S_CONVERT   = 3'd4;
  localparam state_t S_RESULT    = 3'd5;
  localparam state_t S_HOLDOFF   = 3'd6;

  function automatic longint us2cyc(input longint clk_hz, input longint us);
    return clk_hz / 64'sd1_000_000 * us;
  endfunction

  // Q24 factor turning echo cycles into mm (half of 343 m/s round trip).
  function automatic longint dist_k(input longint clk_hz);
    return ((longint'(171500) << 24) + clk_hz / 2) / clk_hz;
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_mc_if.sv
// Sensor pins, control and result stream of the ranger, bundled for the crossbar side.
interface ultrasonic_ranger_mc_if #(
  parameter int N_CH   = 4,
  parameter int DIST_W = 12
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              start;
  logic              continuous;
  logic [N_CH-1:0]   echo;
  logic [N_CH-1:0]   trig;
  logic              busy;
  logic              dist_valid;
  logic              dist_ready;
  logic [CH_W-1:0]   dist_ch;
  logic [DIST_W-1:0] distance;
  logic              timeout;

  modport master (
    output start, continuous, echo, dist_ready,
    input  trig, busy, dist_valid, dist_ch, distance, timeout
  );

  modport slave (
    input  start, continuous, echo, dist_ready,
    output trig, busy, dist_valid, dist_ch, distance, timeout
  );
endinterface

// File: rtl/ultrasonic_ranger_mc_echo_sync.sv
// Two-flop synchroniser for one echo pin plus single-cycle rise/fall pulses.
module ultrasonic_ranger_mc_echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo,
  output logic rise,
  output logic fall
);
  // sh[1] is the synchronised level, sh[2] its previous value.
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst)
    if (!rst) sh <= '0;
    else      sh <= {sh[1:0], echo};

  assign rise =  sh[1] & ~sh[2];
  assign fall = ~sh[1] &  sh[2];
endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// Round-robin ultrasonic ranger: trig, echo timing, mm conversion and a valid/ready result port.
module ultrasonic_ranger_mc
  import ultrasonic_ranger_mc_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int N_CH       = 4,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 38000,
  parameter int HOLDOFF_US = 60000,
  parameter int DIST_W     = 12
) (
  input logic clk,
  input logic rst,
  ultrasonic_ranger_mc_if.slave io
);
  localparam int     CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam longint TRIG_CYC = us2cyc(longint'(CLK_HZ), longint'(TRIG_US));
  localparam longint TO_CYC   = us2cyc(longint'(CLK_HZ), longint'(TIMEOUT_US));
  localparam longint HO_CYC   = us2cyc(longint'(CLK_HZ), longint'(HOLDOFF_US));
  localparam longint CNT_MAX  = (TO_CYC > HO_CYC) ? ((TO_CYC > TRIG_CYC) ? TO_CYC : TRIG_CYC)
                                                  : ((HO_CYC > TRIG_CYC) ? HO_CYC : TRIG_CYC);
  localparam int     CNT_W    = $clog2(CNT_MAX + 1);
  localparam longint K_VAL    = dist_k(longint'(CLK_HZ));
  localparam int     K_W      = $clog2(K_VAL + 1);
  localparam int     PW       = CNT_W + K_W + 1;
  localparam longint DIST_MAX = (longint'(1) << DIST_W) - 1;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
  localparam logic [CNT_W-1:0] HO_LAST   = CNT_W'(HO_CYC - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  state_t             state;
  logic [CH_W-1:0]    ch;
  logic [CNT_W-1:0]   cnt;
  logic [N_CH-1:0]    trig_q;
  logic               busy_q, valid_q, to_q;
  logic [CH_W-1:0]    ch_q;
  logic [DIST_W-1:0]  dist_q;
  logic [N_CH-1:0]    rise_v, fall_v;
  logic               sel_rise, sel_fall;
  logic [PW-1:0]      prod, mm_w;
  logic [DIST_W-1:0]  mm_sat;

  genvar g;
  for (g = 0; g < N_CH; g++) begin : g_ch
    ultrasonic_ranger_mc_echo_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .echo (io.echo[g]),
      .rise (rise_v[g]),
      .fall (fall_v[g])
    );
  end

  // Only the channel currently being pinged can move the FSM.
  assign sel_rise = rise_v[ch];
  assign sel_fall = fall_v[ch];

  assign prod   = PW'(cnt) * PW'(K_VAL) + (PW'(1) << 23);
  assign mm_w   = prod >> 24;
  assign mm_sat = (mm_w > PW'(DIST_MAX)) ? '1 : mm_w[DIST_W-1:0];

  function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] i);
    return N_CH'(1) << i;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ch      <= '0;
      cnt     <= '0;
      trig_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      ch_q    <= '0;
      dist_q  <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (io.start) begin
            state  <= S_TRIG;
            ch     <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            trig_q <= onehot('0);
          end
        S_TRIG:
          if (cnt == TRIG_LAST) begin
            state  <= S_WAIT_RISE;
            cnt    <= '0;
            trig_q <= '0;
          end else cnt <= cnt + CNT_W'(1);
        S_WAIT_RISE:
          if (sel_rise) begin
            state <= S_MEASURE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            state   <= S_RESULT;
            valid_q <= 1'b1;
            ch_q    <= ch;
            dist_q  <= '0;
            to_q    <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
        S_MEASURE:
          if (sel_fall) state <= S_CONVERT;
          else if (cnt == TO_LAST) begin
            state   <= S_RESULT;
            valid_q <= 1'b1;
            ch_q    <= ch;
            dist_q  <= '0;
            to_q    <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
        S_CONVERT: begin
          state   <= S_RESULT;
          valid_q <= 1'b1;
          ch_q    <= ch;
          dist_q  <= mm_sat;
          to_q    <= 1'b0;
        end
        S_RESULT:
          if (io.dist_ready) begin
            state   <= S_HOLDOFF;
            valid_q <= 1'b0;
            cnt     <= '0;
          end
        S_HOLDOFF:
          if (cnt == HO_LAST) begin
            cnt <= '0;
            if (ch != CH_LAST) begin
              ch     <= ch + CH_W'(1);
              state  <= S_TRIG;
              trig_q <= onehot(ch + CH_W'(1));
            end else if (io.continuous) begin
              ch     <= '0;
              state  <= S_TRIG;
              trig_q <= onehot('0);
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else cnt <= cnt + CNT_W'(1);
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.trig       = trig_q;
  assign io.busy       = busy_q;
  assign io.dist_valid = valid_q;
  assign io.dist_ch    = ch_q;
  assign io.distance   = dist_q;
  assign io.timeout    = to_q;
endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Directed scoreboard bench for ultrasonic_ranger_mc, scaled to a 1 MHz clock so sweeps stay short.
module tb_ultrasonic_ranger_mc;
  localparam int CLK_HZ     = 1_000_000;
  localparam int N_CH       = 2;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 6000;
  localparam int HOLDOFF_US = 100;
  localparam int DIST_W     = 10;
  localparam int TRIG_CYC   = 10;
  localparam int TO_CYC     = 6000;
  localparam int HO_CYC     = 100;
  localparam int BOUND      = 20000;

  typedef struct { int ch; int mm; bit to; } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  ultrasonic_ranger_mc_if #(.N_CH(N_CH), .DIST_W(DIST_W)) bus ();

  ultrasonic_ranger_mc #(
    .CLK_HZ(CLK_HZ), .N_CH(N_CH), .TRIG_US(TRIG_US),
    .TIMEOUT_US(TIMEOUT_US), .HOLDOFF_US(HOLDOFF_US), .DIST_W(DIST_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Independent of the RTL's fixed-point factor: 171.5 mm per ms of echo, rounded.
  function automatic int exp_mm(input int h);
    real r;
    int  v;
    r = real'(h) * 171500.0 / real'(CLK_HZ);
    v = $rtoi(r + 0.5);
    return (v > 1023) ? 1023 : v;
  endfunction

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
  endtask

  // h==0: no echo at all; stale: echo on c is already high before its trig.
  task automatic ping(input int c, input int h, input bit exp_to, input bit stale);
    int n;
    n = 0;
    while (bus.trig == '0 && n < BOUND) begin @(negedge clk); n++; end
    chk("trig_onehot", bus.trig, 32'(1 << c));
    n = 0;
    while (bus.trig[c] && n < 100) begin @(negedge clk); n++; end
    chk("trig_width", n, TRIG_CYC);
    if (stale) begin
      repeat (20) @(negedge clk);
      bus.echo[c] = 1'b0;
    end
    if (h == 0) begin
      n = 0;
      do begin
        @(posedge clk); n++; @(negedge clk);
        bus.echo[1-c] = n[5];
      end while (!bus.dist_valid && n < BOUND);
      bus.echo[1-c] = 1'b0;
      chk("timeout_latency", n, TO_CYC);
      q.push_back('{ch: c, mm: 0, to: 1'b1});
    end else begin
      repeat (5) @(negedge clk);
      bus.echo[c] = 1'b1;
      repeat (h) @(negedge clk);
      bus.echo[c] = 1'b0;
      if (exp_to) q.push_back('{ch: c, mm: 0, to: 1'b1});
      else begin
        q.push_back('{ch: c, mm: exp_mm(h), to: 1'b0});
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end
        while (!bus.dist_valid && n < 20);
        chk("fall_to_valid", n, 4);
      end
    end
  endtask

  // Pop and compare one result; optionally stall ready, then check hold-off or sweep end.
  task automatic get_result(input int rdly, input bit next);
    exp_t e;
    int n;
    logic [14:0] hold_exp;
    n = 0;
    while (!bus.dist_valid && n < BOUND) begin @(negedge clk); n++; end
    chk("valid_seen", bus.dist_valid, 1);
    chk("sb_depth", q.size(), 1);
    if (q.size() > 0) e = q.pop_front();
    else e = '{ch: -1, mm: -1, to: 1'b1};
    chk("dist_ch", bus.dist_ch, e.ch);
    chk("distance", bus.distance, e.mm);
    chk("timeout", bus.timeout, e.to);
    hold_exp = {1'b1, 1'(e.ch), 10'(e.mm), e.to, 2'b00};
    repeat (rdly) begin
      @(negedge clk);
      chk("hold_stable", {bus.dist_valid, bus.dist_ch, bus.distance, bus.timeout, bus.trig}, hold_exp);
    end
    bus.dist_ready = 1'b1;
    @(negedge clk);
    bus.dist_ready = 1'b0;
    chk("valid_drop", bus.dist_valid, 0);
    n = 0;
    if (next) begin
      do begin @(posedge clk); n++; @(negedge clk); end
      while (bus.trig == '0 && n < BOUND);
      chk("holdoff_len", n, HO_CYC);
    end else begin
      do begin @(posedge clk); n++; @(negedge clk); end
      while (bus.busy && n < BOUND);
      chk("idle_after_sweep", n, HO_CYC);
      chk("idle_trig", bus.trig, 0);
    end
  endtask

  initial begin
    int n;
    int spur;
    bus.start = 1'b0; bus.continuous = 1'b0; bus.echo = '0; bus.dist_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", bus.trig, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.dist_valid, 0);
    chk("rst_distance", bus.distance, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_dist_ch", bus.dist_ch, 0);
    rst = 1'b1;
    @(negedge clk);

    // nominal range, then rounding up on ch1
    pulse_start();
    ping(0, 5831, 0, 0);
    get_result(0, 1);
    ping(1, 588, 0, 0);
    get_result(0, 0);

    // rounding down with back-pressure, then no echo at all
    pulse_start();
    ping(0, 585, 0, 0);
    get_result(50, 1);
    ping(1, 0, 1, 0);
    get_result(0, 0);

    // saturation, then an echo that is already high before its trig
    pulse_start();
    ping(0, 5990, 0, 0);
    bus.echo[1] = 1'b1;
    get_result(0, 1);
    ping(1, 583, 0, 1);
    get_result(0, 0);

    // continuous sweeps, over-long echo, start while busy, continuous dropped mid-sweep
    bus.continuous = 1'b1;
    pulse_start();
    ping(0, 100, 0, 0);
    pulse_start();
    get_result(0, 1);
    ping(1, 6500, 1, 0);
    get_result(0, 1);
    ping(0, 250, 0, 0);
    bus.continuous = 1'b0;
    get_result(0, 1);
    ping(1, 300, 0, 0);
    get_result(0, 0);
    spur = 0;
    repeat (200) begin @(negedge clk); if (bus.trig != '0 || bus.busy) spur++; end
    chk("stays_idle", spur, 0);

    // reset while trig is high
    pulse_start();
    #2 rst = 1'b0;
    #1 chk("async_rst_trig", bus.trig, 0);
    chk("async_rst_busy", bus.busy, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // reset during MEASURE
    pulse_start();
    n = 0;
    while (bus.trig != '0 && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    bus.echo[0] = 1'b1;
    repeat (50) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    #2 rst = 1'b0;
    #1 chk("measure_rst_busy", bus.busy, 0);
    chk("measure_rst_valid", bus.dist_valid, 0);
    @(negedge clk); rst = 1'b1;
    bus.echo[0] = 1'b0;
    spur = 0;
    repeat (300) begin @(negedge clk); if (bus.dist_valid || bus.trig != '0 || bus.busy) spur++; end
    chk("no_spurious_result", spur, 0);

    // reset while a result is being offered
    pulse_start();
    n = 0;
    while (bus.trig != '0 && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    bus.echo[0] = 1'b1;
    repeat (100) @(negedge clk);
    bus.echo[0] = 1'b0;
    n = 0;
    while (!bus.dist_valid && n < 50) begin @(negedge clk); n++; end
    chk("pre_rst_valid", bus.dist_valid, 1);
    #2 rst = 1'b0;
    #1 chk("result_rst_valid", bus.dist_valid, 0);
    chk("result_rst_distance", bus.distance, 0);
    @(negedge clk); rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_idle", {bus.busy, bus.dist_valid}, 0);

    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
